// File: rtl/fp_result_normalize_pkg.sv
// Shared types and constants for the FP adder result-normalize stage.
package fp_pkg;

  localparam int EXP_W   = 8;
  localparam int MANT_W  = 23;
  localparam int EXP_MAX = (1 << EXP_W) - 1;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] frac;
  } fp32_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONVERT,
    S_NORM,
    S_PACK,
    S_OUT
  } state_t;

endpackage

// File: rtl/fp_result_normalize_pack.sv
// Combinational packer: normalized sign/exp/mag -> binary32 plus zero/overflow flags.
// FPN_ROUND_NEAREST_EN adds a guard input and ties-to-even increment.
module fp_pack
  import fp_pkg::*;
(
`ifdef FPN_ROUND_NEAREST_EN
  input  logic              guard,
`endif
  input  logic              sign,
  input  logic [EXP_W:0]    exp,
  input  logic [MANT_W+1:0] mag,
  output fp32_t             result,
  output logic              zero,
  output logic              overflow
);

  logic [MANT_W+1:0] m;
  logic [EXP_W:0]    e;

  always_comb begin
    m = mag;
    e = exp;
`ifdef FPN_ROUND_NEAREST_EN
    if (guard && mag[0]) begin
      m = mag + 1'b1;
    end
`endif
    // A rounding carry lands in the top bit; renormalize once before classifying.
    if (m[MANT_W+1]) begin
      m = m >> 1;
      e = e + 1'b1;
    end

    result   = '0;
    zero     = 1'b0;
    overflow = 1'b0;
    if (m == '0) begin
      zero = 1'b1;
    end else if (e >= (EXP_W+1)'(EXP_MAX)) begin
      result.sign = sign;
      result.exp  = '1;
      overflow    = 1'b1;
    end else if (!m[MANT_W]) begin
      result.sign = sign;
      result.frac = m[MANT_W-1:0];
    end else begin
      result.sign = sign;
      result.exp  = e[EXP_W-1:0];
      result.frac = m[MANT_W-1:0];
    end
  end

endmodule

// File: rtl/fp_result_normalize.sv
// Post-adder stage: two's-complement mantissa sum -> sign/magnitude, one-bit-per-cycle
// normalization, IEEE-754 binary32 pack. Optional rounding via FPN_ROUND_NEAREST_EN.
module fp_result_normalize
  import fp_pkg::*;
#(
  parameter int EXP_W  = fp_pkg::EXP_W,
  parameter int MANT_W = fp_pkg::MANT_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [MANT_W+2:0]         in_sum,
  input  logic [EXP_W-1:0]          in_exp,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2+EXP_W+MANT_W-2:0] out_result,
  output logic                      out_overflow,
  output logic                      out_zero
);

  localparam logic [EXP_W:0] EXP_ONE = (EXP_W+1)'(1);

  state_t            state;
  logic [MANT_W+2:0] sum;
  logic [EXP_W:0]    exp;
  logic [MANT_W+1:0] mag;
  logic              sign;
  logic [MANT_W+1:0] mag_abs;
  fp32_t             pack_result;
  logic              pack_zero;
  logic              pack_overflow;
`ifdef FPN_ROUND_NEAREST_EN
  logic              guard;
`endif

  assign in_ready = (state == S_IDLE) && !reset;
  // Negating the most negative sum wraps to zero in the magnitude width.
  assign mag_abs  = sum[MANT_W+2] ? (MANT_W+2)'(-sum) : sum[MANT_W+1:0];

  fp_pack u_pack (
`ifdef FPN_ROUND_NEAREST_EN
    .guard    (guard),
`endif
    .sign     (sign),
    .exp      (exp),
    .mag      (mag),
    .result   (pack_result),
    .zero     (pack_zero),
    .overflow (pack_overflow)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_overflow <= 1'b0;
      out_zero     <= 1'b0;
      sum          <= '0;
      exp          <= '0;
      mag          <= '0;
      sign         <= 1'b0;
`ifdef FPN_ROUND_NEAREST_EN
      guard        <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            sum   <= in_sum;
            exp   <= (in_exp == '0) ? EXP_ONE : {1'b0, in_exp};
            state <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          sign  <= sum[MANT_W+2];
          mag   <= mag_abs;
`ifdef FPN_ROUND_NEAREST_EN
          guard <= 1'b0;
`endif
          state <= S_NORM;
        end
        S_NORM: begin
          if (mag[MANT_W+1]) begin
`ifdef FPN_ROUND_NEAREST_EN
            guard <= mag[0];
`endif
            mag <= mag >> 1;
            exp <= exp + EXP_ONE;
          end else if (mag != '0 && !mag[MANT_W] && exp > EXP_ONE) begin
            mag <= mag << 1;
            exp <= exp - EXP_ONE;
          end else begin
            state <= S_PACK;
          end
        end
        S_PACK: begin
          out_result   <= pack_result;
          out_zero     <= pack_zero;
          out_overflow <= pack_overflow;
          out_valid    <= 1'b1;
          state        <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
